mul_pipe_unit: RTL

Parametrised, fully pipelined RV32M/RV64M multiply unit for the execute stage. It implements MUL, MULH, MULHSU and MULHU at one operation per cycle with configurable latency. A valid/ready handshake on both sides carries backpressure, a destination tag travels with each operation, and a flush input kills in-flight work on redirect. It replaces the fixed-latency, stall-signal multiplier between the ID/EX pipeline register and the writeback mux.

---
 rtl/mul_pkg.sv | 43 ++++
 rtl/mul_pipe_core.sv | 61 ++++++
 rtl/mul_pipe_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and the operand-extension helper for the M-extension multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

  // Widest supported operand; narrower units zero-pad into this width.
  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_op_t;

  // Both operands widened by one bit so a single signed multiplier covers
  // signed, unsigned and mixed-sign products.
  typedef struct packed {
    logic [XLEN_MAX:0] a;
    logic [XLEN_MAX:0] b;
  } ext_ops_t;

  // a/b hold an xlen-bit operand in their low bits; the result carries each
  // operand extended from bit xlen-1 upward according to the opcode.
  function automatic ext_ops_t ext_operands(input logic [2:0]          op,
                                            input logic [XLEN_MAX-1:0] a,
                                            input logic [XLEN_MAX-1:0] b,
                                            input int                  xlen);
    ext_ops_t r;
    logic     a_sgn;
    logic     b_sgn;
    a_sgn = (op != MULHU) && a[xlen-1];
    b_sgn = ((op == MUL) || (op == MULH)) && b[xlen-1];
    for (int i = 0; i < XLEN_MAX; i++) begin
      r.a[i] = (i < xlen) ? a[i] : a_sgn;
      r.b[i] = (i < xlen) ? b[i] : b_sgn;
    end
    r.a[XLEN_MAX] = a_sgn;
    r.b[XLEN_MAX] = b_sgn;
    return r;
  endfunction

endpackage

// File: rtl/mul_pipe_core.sv
// Signed (XLEN+1)x(XLEN+1) multiply with STAGES-1 balancing registers.
// Latency: STAGES-1 cycles (combinational when STAGES = 1).
// Backpressure: every register advances only on i_en; all hold otherwise.
// Ports: clk/reset, i_en shared advance, i_a/i_b extended operands,
//        o_prod low 2*XLEN bits of the signed product.
module mul_pipe_core #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [XLEN:0]     i_a,
  input  logic [XLEN:0]     i_b,
  output logic [2*XLEN-1:0] o_prod
);

  // Only the low 2*XLEN bits are ever selected, so the product is formed at
  // that width; the dropped top bits cannot influence the kept ones.
  localparam int PW = 2 * XLEN;

  if (STAGES == 1) begin : g_comb
    assign o_prod = PW'($signed(i_a)) * PW'($signed(i_b));
  end else begin : g_pipe
    logic [XLEN:0] r_a;
    logic [XLEN:0] r_b;
    logic [PW-1:0] w_mul;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_a <= '0;
        r_b <= '0;
      end else if (i_en) begin
        r_a <= i_a;
        r_b <= i_b;
      end
    end

    assign w_mul = PW'($signed(r_a)) * PW'($signed(r_b));

    if (STAGES == 2) begin : g_noret
      assign o_prod = w_mul;
    end else begin : g_ret
      // Retiming registers behind the multiplier so synthesis can pull them
      // into the DSP pipeline.
      logic [PW-1:0] r_ret [STAGES-2];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < STAGES - 2; i++) r_ret[i] <= '0;
        end else if (i_en) begin
          r_ret[0] <= w_mul;
          for (int i = 1; i < STAGES - 2; i++) r_ret[i] <= r_ret[i-1];
        end
      end

      assign o_prod = r_ret[STAGES-3];
    end
  end

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined RV32M/RV64M multiply unit (MUL/MULH/MULHSU/MULHU) with tag and flush.
// Latency: STAGES cycles from in_valid sampled to out_valid; 1 op/cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
// Ports: clk, reset (async, active-high), flush; in_valid/in_ready with
//        funct3, a, b, in_tag; out_valid/out_ready with result, out_tag; busy.
module mul_pipe_unit
  import mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic              w_adv;
  logic              w_accept;
  ext_ops_t          w_ext;
  logic [XLEN:0]     w_a_ext;
  logic [XLEN:0]     w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [2:0]        w_sel_op;
  logic [XLEN-1:0]   w_sel_res;

  logic [STAGES-1:0] r_vld;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [XLEN-1:0]   r_res;

  // Whole pipe moves as one; bubbles are kept, never collapsed.
  assign w_adv    = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_adv && !flush && !reset;
  assign w_accept = in_valid && in_ready;

  assign w_ext   = ext_operands(funct3, XLEN_MAX'(a), XLEN_MAX'(b), XLEN);
  assign w_a_ext = w_ext.a[XLEN:0];
  assign w_b_ext = w_ext.b[XLEN:0];

  mul_pipe_core #(
    .XLEN   (XLEN),
    .STAGES (STAGES)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_adv),
    .i_a    (w_a_ext),
    .i_b    (w_b_ext),
    .o_prod (w_prod)
  );

  // The opcode is needed only at the final stage for result selection, so
  // it rides alongside the core registers and is consumed one stage early.
  if (STAGES == 1) begin : g_op_direct
    assign w_sel_op = funct3;
  end else begin : g_op_pipe
    logic [2:0] r_op [STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < STAGES - 1; i++) r_op[i] <= '0;
      end else if (w_adv) begin
        r_op[0] <= funct3;
        for (int i = 1; i < STAGES - 1; i++) r_op[i] <= r_op[i-1];
      end
    end

    assign w_sel_op = r_op[STAGES-2];
  end

  // Reserved funct3 values (1xx) flow through normally and return zero.
  always_comb begin
    w_sel_res = '0;
    case (w_sel_op)
      MUL:                 w_sel_res = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU: w_sel_res = w_prod[2*XLEN-1:XLEN];
      default:             w_sel_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_res <= '0;
      for (int i = 0; i < STAGES; i++) r_tag[i] <= '0;
    end else begin
      if (w_adv) begin
        r_res    <= w_sel_res;
        r_tag[0] <= in_tag;
        for (int i = 1; i < STAGES; i++) r_tag[i] <= r_tag[i-1];
      end
      // Flush only kills valid bits; stale data/tags are harmless.
      if (flush) begin
        r_vld <= '0;
      end else if (w_adv) begin
        r_vld[0] <= w_accept;
        for (int i = 1; i < STAGES; i++) r_vld[i] <= r_vld[i-1];
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign result    = r_res;
  assign out_tag   = r_tag[STAGES-1];
  assign busy      = |r_vld;

endmodule
